batch_norm_stream: RTL and testbench

- Streaming, parameterised successor to the flat-bus batch normalization block.
- Applies per-channel affine normalisation y = sat(((x * gamma[c]) >>> FRAC_BITS) + beta[c]), with optional fused ReLU, to a channel-interleaved feature-map stream.
- Sits between a conv layer output and the next layer, with valid/ready handshakes on both sides.
- Coefficients are loaded at runtime through a write port instead of being hard-wired.

---
 rtl/bn_pkg.sv | 42 ++++
 rtl/bn_coef_bank.sv | 47 ++++
 rtl/batch_norm_stream.sv | 215 +++++++++++++++++++++
 tb/tb_batch_norm_stream.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bn_pkg.sv
// Shared definitions for the streaming batch-normalisation block.
// Contents: default parameter values, the fixed-point unity constant, the stream-level FSM
// state type, a coefficient-pair record at default widths and the saturating narrowing helper.
package bn_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_FRAC_BITS  = 8;
    localparam int unsigned DEF_COEF_WIDTH = 16;
    localparam int unsigned DEF_FILTERS    = 64;
    localparam int unsigned DEF_INPUT      = 30;

    // 1.0 in the default Q format
    localparam int unsigned ONE = 1 << DEF_FRAC_BITS;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } bn_state_e;

    typedef struct packed {
        logic signed [DEF_COEF_WIDTH-1:0] gamma;
        logic signed [DEF_DATA_WIDTH-1:0] beta;
    } bn_coef_t;

    // Clamp a signed value to the range of a signed 'width'-bit number. The caller keeps the
    // low 'width' bits of the result.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] wide,
                                                     input int unsigned        width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (wide > max_v) begin
            return max_v;
        end
        if (wide < min_v) begin
            return min_v;
        end
        return wide;
    endfunction

endpackage

// File: rtl/bn_coef_bank.sv
// Per-channel gamma/beta register file.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset (entries return to 1.0 / 0)
//   wr_en, wr_addr      write strobe and channel index (caller guarantees wr_addr < FILTERS)
//   wr_gamma, wr_beta   values written at the clock edge
//   rd_addr             channel index for the combinational read
//   rd_gamma, rd_beta   coefficients of channel rd_addr
module bn_coef_bank
    import bn_pkg::*;
#(
    parameter int unsigned FILTERS    = DEF_FILTERS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(FILTERS)-1:0]   wr_addr,
    input  logic [COEF_WIDTH-1:0]        wr_gamma,
    input  logic [DATA_WIDTH-1:0]        wr_beta,
    input  logic [$clog2(FILTERS)-1:0]   rd_addr,
    output logic [COEF_WIDTH-1:0]        rd_gamma,
    output logic [DATA_WIDTH-1:0]        rd_beta
);

    localparam logic [COEF_WIDTH-1:0] GammaOne = COEF_WIDTH'(1 << FRAC_BITS);

    logic [COEF_WIDTH-1:0] gamma_q [FILTERS];
    logic [DATA_WIDTH-1:0] beta_q  [FILTERS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FILTERS); i++) begin
                gamma_q[i] <= GammaOne;
                beta_q[i]  <= '0;
            end
        end else if (wr_en) begin
            gamma_q[wr_addr] <= wr_gamma;
            beta_q[wr_addr]  <= wr_beta;
        end
    end

    assign rd_gamma = gamma_q[rd_addr];
    assign rd_beta  = beta_q[rd_addr];

endmodule

// File: rtl/batch_norm_stream.sv
// Streaming per-channel batch normalisation: y = sat(((x * gamma[c]) >>> FRAC_BITS) + beta[c]),
// optional fused ReLU, on a channel-interleaved stream (beat k belongs to channel k mod FILTERS).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   clear                       synchronous abort: empties the pipeline, zeroes the counters
//   relu_en                     ReLU enable, captured with each accepted input beat
//   coef_wr_en/addr/gamma/beta  coefficient write port, honoured only while idle
//   coef_err                    one-cycle pulse after a rejected write
//   in_valid/in_ready/in_data   input stream
//   out_valid/out_ready/out_data/out_last   output stream, out_last on the final beat of a frame
//   frame_done                  one-cycle pulse after the out_last beat is taken
//   busy                        frame in progress or pipeline not empty
module batch_norm_stream
    import bn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
    parameter int unsigned COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int unsigned FILTERS    = DEF_FILTERS,
    parameter int unsigned INPUT      = DEF_INPUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         relu_en,
    input  logic                         coef_wr_en,
    input  logic [$clog2(FILTERS)-1:0]   coef_addr,
    input  logic [COEF_WIDTH-1:0]        coef_gamma,
    input  logic [DATA_WIDTH-1:0]        coef_beta,
    output logic                         coef_err,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic                         frame_done,
    output logic                         busy
);

    localparam int unsigned AddrWidth = $clog2(FILTERS);
    localparam int unsigned Pixels    = INPUT * INPUT;
    localparam int unsigned PixWidth  = (Pixels > 1) ? $clog2(Pixels) : 1;
    localparam int unsigned ProdWidth = DATA_WIDTH + COEF_WIDTH;
    localparam int unsigned SumWidth  = ProdWidth + 1;

    localparam logic [AddrWidth-1:0] LastCh  = AddrWidth'(FILTERS - 1);
    localparam logic [PixWidth-1:0]  LastPix = PixWidth'(Pixels - 1);

    bn_state_e               state_q, state_d;
    logic [AddrWidth-1:0]    ch_q, ch_d;
    logic [PixWidth-1:0]     pix_q, pix_d;

    // S1: product plus the per-beat side information it travels with
    logic                        s1_valid_q;
    logic signed [ProdWidth-1:0] s1_prod_q;
    logic signed [DATA_WIDTH-1:0] s1_beta_q;
    logic                        s1_relu_q;
    logic                        s1_last_q;

    // S2: final result, drives the output port
    logic                    s2_valid_q;
    logic [DATA_WIDTH-1:0]   s2_data_q;
    logic                    s2_last_q;

    logic frame_done_q;
    logic coef_err_q;

    logic adv1, adv2, in_fire, out_fire, last_beat;
    logic coef_addr_ok, coef_wr_ok;

    logic [COEF_WIDTH-1:0]        rd_gamma;
    logic [DATA_WIDTH-1:0]        rd_beta;
    logic signed [DATA_WIDTH-1:0] in_s;
    logic signed [COEF_WIDTH-1:0] gamma_s;
    logic signed [ProdWidth-1:0]  mul;
    logic signed [ProdWidth-1:0]  shifted;
    logic signed [SumWidth-1:0]   sum;
    logic [DATA_WIDTH-1:0]        s2_result;

    bn_coef_bank #(
        .FILTERS    (FILTERS),
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_coef_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (coef_wr_ok),
        .wr_addr  (coef_addr),
        .wr_gamma (coef_gamma),
        .wr_beta  (coef_beta),
        .rd_addr  (ch_q),
        .rd_gamma (rd_gamma),
        .rd_beta  (rd_beta)
    );

    // Handshake: each stage can take a new beat when it is empty or the next stage advances.
    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1 && !clear;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    assign busy      = (state_q == StRun) || s1_valid_q || s2_valid_q;
    assign last_beat = (ch_q == LastCh) && (pix_q == LastPix);

    assign coef_addr_ok = ({1'b0, coef_addr} < (AddrWidth + 1)'(FILTERS));
    assign coef_wr_ok   = coef_wr_en && !busy && coef_addr_ok;

    // Frame FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_fire && !last_beat) state_d = StRun;
            StRun:   if (in_fire && last_beat)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (clear) begin
            state_d = StIdle;
        end
    end

    // Channel / pixel position of the next input beat
    always_comb begin
        ch_d  = ch_q;
        pix_d = pix_q;
        if (clear) begin
            ch_d  = '0;
            pix_d = '0;
        end else if (in_fire) begin
            if (last_beat) begin
                ch_d  = '0;
                pix_d = '0;
            end else if (ch_q == LastCh) begin
                ch_d  = '0;
                pix_d = pix_q + PixWidth'(1);
            end else begin
                ch_d = ch_q + AddrWidth'(1);
            end
        end
    end

    // S1 multiply, operands sign-extended to the full product width
    always_comb begin
        in_s    = in_data;
        gamma_s = rd_gamma;
        mul     = ProdWidth'(in_s) * ProdWidth'(gamma_s);
    end

    // S2 shift (floor), add beta, saturate, optional ReLU
    always_comb begin
        shifted   = s1_prod_q >>> FRAC_BITS;
        sum       = SumWidth'(shifted) + SumWidth'(s1_beta_q);
        s2_result = DATA_WIDTH'(sat_trunc({{(64 - SumWidth){sum[SumWidth-1]}}, sum}, DATA_WIDTH));
        if (s1_relu_q && s2_result[DATA_WIDTH-1]) begin
            s2_result = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            pix_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_prod_q    <= '0;
            s1_beta_q    <= '0;
            s1_relu_q    <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            coef_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            pix_q        <= pix_d;
            coef_err_q   <= coef_wr_en && !coef_wr_ok;
            // An out_last handshake coinciding with clear still completes, but the frame is
            // treated as aborted.
            frame_done_q <= out_fire && s2_last_q && !clear;

            if (clear) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end else begin
                if (adv1) s1_valid_q <= in_fire;
                if (adv2) s2_valid_q <= s1_valid_q;
            end

            if (in_fire) begin
                s1_prod_q <= mul;
                s1_beta_q <= rd_beta;
                s1_relu_q <= relu_en;
                s1_last_q <= last_beat;
            end

            // Only load on advance so the output holds while stalled
            if (adv2 && s1_valid_q && !clear) begin
                s2_data_q <= s2_result;
                s2_last_q <= s1_last_q;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_last   = s2_valid_q && s2_last_q;
    assign frame_done = frame_done_q;
    assign coef_err   = coef_err_q;

endmodule

// File: tb/tb_batch_norm_stream.sv
// Self-checking bench for batch_norm_stream (FILTERS=4, INPUT=2, 16-bit Q8.8).
// A reference model computes every accepted beat with plain integer arithmetic and queues the
// expected output; outputs are compared in order as they are taken.
module tb_batch_norm_stream;

    localparam int F     = 4;
    localparam int IN    = 2;
    localparam int BEATS = F * IN * IN;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        relu_en = 1'b0;
    logic        coef_wr_en = 1'b0;
    logic [1:0]  coef_addr = '0;
    logic [15:0] coef_gamma = '0;
    logic [15:0] coef_beta = '0;
    logic        coef_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        frame_done;
    logic        busy;

    batch_norm_stream #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (8),
        .COEF_WIDTH (16),
        .FILTERS    (F),
        .INPUT      (IN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .relu_en    (relu_en),
        .coef_wr_en (coef_wr_en),
        .coef_addr  (coef_addr),
        .coef_gamma (coef_gamma),
        .coef_beta  (coef_beta),
        .coef_err   (coef_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          m_gamma[F];
    int          m_beta[F];
    int          beat_k = 0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          err_pulses = 0;
    int          done_pulses = 0;
    int          done_cyc = -1;
    int          last_out_cyc = -1;
    logic [15:0] last_out_data = '0;
    logic        held_valid = 1'b0;
    logic [15:0] held_data = '0;
    logic        held_last = 1'b0;
    logic        fired_in = 1'b0;
    logic        lat_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bn_ref(input logic [15:0] x, input int g, input int b,
                                           input logic relu);
        longint v;
        v = longint'($signed(x)) * longint'(g);
        v = v >>> 8;
        v = v + longint'(b);
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        if (relu && v < 0) v = 0;
        return v[15:0];
    endfunction

    task automatic model_accept(input logic [15:0] x, input logic r);
        exp_t e;
        e.data = bn_ref(x, m_gamma[beat_k % F], m_beta[beat_k % F], r);
        e.last = (beat_k == BEATS - 1);
        e.cyc  = cyc;
        exp_q.push_back(e);
        beat_k = (beat_k == BEATS - 1) ? 0 : beat_k + 1;
    endtask

    task automatic model_reset_coefs();
        for (int i = 0; i < F; i++) begin
            m_gamma[i] = 256;
            m_beta[i]  = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven; observes this cycle and
    // returns at the next falling edge.
    task automatic step();
        exp_t e;
        #1;
        cyc++;
        if (coef_err) err_pulses++;
        if (frame_done) begin
            done_pulses++;
            done_cyc = cyc;
        end
        if (held_valid) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(held_data));
            check("stall_last", 32'(out_last), 32'(held_last));
        end
        fired_in = in_valid && in_ready;
        if (fired_in) model_accept(in_data, relu_en);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_last", 32'(out_last), 32'(e.last));
                if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd2);
                last_out_data = out_data;
                if (out_last) last_out_cyc = cyc;
            end
        end
        held_valid = out_valid && !out_ready;
        held_data  = out_data;
        held_last  = out_last;
        if (clear) begin
            check("clear_in_ready", 32'(in_ready), 32'd0);
            exp_q.delete();
            beat_k     = 0;
            held_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [15:0] g, input logic [15:0] b);
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        coef_wr_en = 1'b1;
        coef_addr  = a;
        coef_gamma = g;
        coef_beta  = b;
        step();
        coef_wr_en = 1'b0;
        m_gamma[a] = int'($signed(g));
        m_beta[a]  = int'($signed(b));
        step();
    endtask

    task automatic send_beat(input logic [15:0] x, input logic r);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = x;
        relu_en   = r;
        out_ready = 1'b1;
        do begin
            step();
            n++;
        end while (!fired_in && n < 10);
        in_valid = 1'b0;
        check("send_accepted", 32'(fired_in), 32'd1);
    endtask

    // Random traffic until n beats are accepted; optional coefficient strobe at step wr_at.
    task automatic stream(input int n, input int pv, input int pr, input int wr_at);
        int sent = 0;
        int c = 0;
        while (sent < n && c < 2000) begin
            in_valid   = ($urandom_range(99) < pv);
            in_data    = 16'($urandom);
            relu_en    = 1'($urandom);
            out_ready  = ($urandom_range(99) < pr);
            coef_wr_en = (c == wr_at);
            step();
            if (fired_in) sent++;
            c++;
        end
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        check("stream_sent", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        step();
        step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        step();
        check("clear_out_valid", 32'(out_valid), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int e0;
        model_reset_coefs();

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_coef_err", 32'(coef_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic value and 2-cycle latency
        write_coef(2'd0, 16'h0200, 16'h0100);
        lat_chk = 1'b1;
        send_beat(16'h0180, 1'b0);
        drain();
        lat_chk = 1'b0;
        check("basic_value", 32'(last_out_data), 32'h0400);
        do_clear();

        // Saturation and ReLU
        write_coef(2'd0, 16'h7FFF, 16'h7FFF);
        write_coef(2'd1, 16'h7FFF, 16'h0000);
        write_coef(2'd2, 16'h0100, 16'h0000);
        write_coef(2'd3, 16'h0100, 16'h0000);
        send_beat(16'h7FFF, 1'b0);
        drain();
        check("sat_pos", 32'(last_out_data), 32'h7FFF);
        send_beat(16'h8000, 1'b0);
        drain();
        check("sat_neg", 32'(last_out_data), 32'h8000);
        send_beat(16'hFF00, 1'b0);
        drain();
        check("relu_off", 32'(last_out_data), 32'hFF00);
        send_beat(16'hFF00, 1'b1);
        drain();
        check("relu_on", 32'(last_out_data), 32'h0000);
        do_clear();

        // Framing with distinct per-channel coefficients
        write_coef(2'd0, 16'h0100, 16'h0005);
        write_coef(2'd1, 16'h0200, 16'hFFF0);
        write_coef(2'd2, 16'h0080, 16'h0000);
        write_coef(2'd3, 16'h0300, 16'h0010);
        d0 = done_pulses;
        stream(BEATS, 100, 100, -1);
        drain();
        check("frame_done_count", 32'(done_pulses - d0), 32'd1);
        check("frame_done_timing", 32'(done_cyc), 32'(last_out_cyc + 1));
        check("idle_after_frame", 32'(busy), 32'd0);

        // Mid-frame write is rejected; same write when idle applies to the next frame
        coef_addr  = 2'd0;
        coef_gamma = 16'h0400;
        coef_beta  = 16'h0010;
        e0 = err_pulses;
        d0 = done_pulses;
        stream(BEATS, 100, 100, 5);
        drain();
        check("mid_frame_err", 32'(err_pulses - e0), 32'd1);
        write_coef(2'd0, 16'h0400, 16'h0010);
        check("idle_write_no_err", 32'(err_pulses - e0), 32'd1);
        stream(BEATS, 100, 100, -1);
        drain();
        check("two_frames_done", 32'(done_pulses - d0), 32'd2);

        // Random backpressure over three frames
        d0 = done_pulses;
        stream(3 * BEATS, 60, 50, -1);
        drain();
        check("bp_frames_done", 32'(done_pulses - d0), 32'd3);
        check("bp_idle", 32'(busy), 32'd0);

        // Clear mid-frame, then a full frame restarting at channel 0
        stream(7, 100, 70, -1);
        do_clear();
        d0 = done_pulses;
        stream(BEATS, 80, 80, -1);
        drain();
        check("post_clear_frame", 32'(done_pulses - d0), 32'd1);

        // Asynchronous reset mid-frame
        stream(5, 100, 50, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_last", 32'(out_last), 32'd0);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        check("arst_coef_err", 32'(coef_err), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        beat_k     = 0;
        held_valid = 1'b0;
        model_reset_coefs();
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(16'h1234, 1'b0);
        drain();
        check("post_reset_gamma_one", 32'(last_out_data), 32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
